// File: rtl/led_arbiter_pkg.sv
// Shared types and constants for the status-LED arbiter.
// The state enum and the per-requester blink-rate codes live here.
package led_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] RATE_SOLID = 2'd0;
    localparam logic [1:0] RATE_1     = 2'd1;
    localparam logic [1:0] RATE_2     = 2'd2;
    localparam logic [1:0] RATE_4     = 2'd3;

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides clk down to a one-cycle tick pulse every TICK_DIV cycles.
// A synchronous clear restarts the count so tick phase follows the caller.
module led_tick_prescaler #(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing one status LED among NUM_REQ requesters.
// Define LED_ARBITER_PREEMPT0_EN to give requester 0 absolute, preempting priority.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TICK_DIV   = 12000000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] rate,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 led,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(HOLD_TICKS + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold_ticks
        $error("HOLD_TICKS must be >= 1");
    end

    state_e        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [1:0]    rate_q;
    logic [TW-1:0] tick_cnt;
    logic [TW+1:0] tnum;
    logic [PW-1:0] sel;
    logic          sel_vld;
    logic          tick;
    logic          clear;
    logic          leave;
    logic          toggle;

    // Phases restart on entry to GRANT (prescaler held clear in IDLE) and to GAP.
    assign clear = (state == IDLE) || leave;
    assign busy  = (state != IDLE);

    led_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // Walk downward so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[PW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                sel     = PW'((int'(rr_ptr) + k) % NUM_REQ);
                sel_vld = 1'b1;
            end
        end
`ifdef LED_ARBITER_PREEMPT0_EN
        if (req[0]) begin
            sel     = '0;
            sel_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        leave = 1'b0;
        if (state == GRANT) begin
            if (!req[gidx]) begin
                leave = 1'b1;
            end
            if (tick && (tick_cnt == TW'(HOLD_TICKS - 1))) begin
                leave = 1'b1;
            end
`ifdef LED_ARBITER_PREEMPT0_EN
            if ((gidx != '0) && req[0]) begin
                leave = 1'b1;
            end
`endif
        end
    end

    // tnum is the 1-based number of the tick occurring this cycle.
    assign tnum = {2'b00, tick_cnt} + (TW + 2)'(1);

    always_comb begin
        case (rate_q)
            RATE_SOLID: toggle = 1'b0;
            RATE_1:     toggle = 1'b1;
            RATE_2:     toggle = (tnum[0] == 1'b0);
            RATE_4:     toggle = (tnum[1:0] == 2'b00);
            default:    toggle = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            led      <= 1'b0;
            rr_ptr   <= '0;
            gidx     <= '0;
            rate_q   <= RATE_SOLID;
            tick_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        state    <= GRANT;
                        gidx     <= sel;
                        grant    <= NUM_REQ'(1) << sel;
                        rate_q   <= rate[{sel, 1'b0} +: 2];
                        led      <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (leave) begin
                        state    <= GAP;
                        grant    <= '0;
                        led      <= 1'b0;
                        tick_cnt <= '0;
`ifdef LED_ARBITER_PREEMPT0_EN
                        if (gidx != '0) begin
                            rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
                        end
`else
                        rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
`endif
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                        if (toggle) begin
                            led <= ~led;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: randomized traffic against a
// transaction-level model of grant order, grant length and blink pattern.
module tb_led_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int HT = 3;
    localparam int GL = TD * HT;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [2*N-1:0] rate  = '0;
    logic [N-1:0]   grant;
    logic           led;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int ptr   = 0;

    led_arbiter #(
        .NUM_REQ   (N),
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .rate (rate),
        .grant(grant),
        .led  (led),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // LED level in cycle c (1-based) of a grant: toggles once per 2^(r-1) completed ticks.
    function automatic logic exp_led(input logic [1:0] r, input int c);
        int t;
        t = (c - 1) / TD;
        if (r == 2'd0) return 1'b1;
        return ((t / (1 << (int'(r) - 1))) % 2) == 0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] rq, input int p);
`ifdef LED_ARBITER_PREEMPT0_EN
        if (rq[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Called in cycle 1 of a grant; returns in the IDLE cycle after its gap.
    task automatic run_grant(input int g, input logic [1:0] r, input int drop_at,
                             input int raise0_at);
        int           len;
        logic [N-1:0] exp_g;
        len = GL;
        if (drop_at > 0) len = drop_at;
`ifdef LED_ARBITER_PREEMPT0_EN
        if (raise0_at > 0 && g != 0 && raise0_at < len) len = raise0_at;
`endif
        exp_g    = '0;
        exp_g[g] = 1'b1;
        for (int c = 1; c <= len; c++) begin
            tests++;
            if (grant !== exp_g) begin
                fails++;
                $display("FAIL grant cycle %0d: got %b want %b", c, grant, exp_g);
            end
            tests++;
            if (led !== exp_led(r, c)) begin
                fails++;
                $display("FAIL led cycle %0d rate %0d: got %b want %b", c, r, led,
                         exp_led(r, c));
            end
            rate = 8'($urandom);
            if (c == drop_at) req[g] = 1'b0;
            if (c == raise0_at) req[0] = 1'b1;
            step();
        end
        for (int c = 1; c <= TD; c++) begin
            tests++;
            if (grant !== '0 || led !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL gap cycle %0d: got grant %b led %b busy %b want 0000 0 1",
                         c, grant, led, busy);
            end
            if (c == 1 && drop_at > 0) req[g] = 1'b1;
            step();
        end
        tests++;
        if (grant !== '0 || led !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle: got grant %b led %b busy %b want 0000 0 0", grant, led, busy);
        end
    endtask

    task automatic serve(input int drop_at, input int raise0_at);
        int         g;
        logic [1:0] r;
        g = model_pick(req, ptr);
        if (g < 0) begin
            fails++;
            $display("FAIL serve: bench issued empty request");
            return;
        end
        r = rate[2*g +: 2];
        step();
        run_grant(g, r, drop_at, raise0_at);
`ifdef LED_ARBITER_PREEMPT0_EN
        if (g != 0) ptr = (g + 1) % N;
`else
        ptr = (g + 1) % N;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if (grant !== '0) begin fails++; $display("FAIL reset grant: got %b want 0", grant); end
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL reset led: got %b want 0", led); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        reset = 1'b0;
        ptr   = 0;
    endtask

    task automatic test_round_robin();
        req  = 4'b1111;
        rate = 8'($urandom);
        for (int i = 0; i < 5; i++) serve(0, 0);
    endtask

    task automatic test_single_rate1();
        req  = 4'b0010;
        rate = 8'b00_00_01_00;
        serve(0, 0);
    endtask

    task automatic test_rates();
        req  = 4'b0100;
        rate = 8'b00_00_00_00;
        serve(0, 0);
        req  = 4'b0100;
        rate = 8'b00_11_00_00;
        serve(0, 0);
        req  = 4'b1000;
        rate = 8'b10_00_00_00;
        serve(0, 0);
    endtask

    task automatic test_early_release();
        req  = 4'b0010;
        rate = 8'b00_00_01_00;
        serve(6, 0);
        req = 4'b0001;
        serve(GL, 0);
        req = 4'b0001;
        serve(1, 0);
    endtask

    task automatic test_raise0();
        req  = 4'b0100;
        rate = 8'($urandom);
        serve(0, 5);
        serve(0, 0);
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 30; i++) begin
            req  = 4'($urandom_range(1, 15));
            rate = 8'($urandom);
            d    = $urandom_range(0, 16);
            if (d > GL) d = 0;
            serve(d, 0);
        end
    endtask

    task automatic test_reset_mid_grant();
        req  = 4'b0001;
        rate = 8'($urandom);
        serve(0, 0);
        req = 4'b0100;
        step();
        tests++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL pre-reset grant: got %b want 0100", grant);
        end
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        tests++;
        if (grant !== '0 || led !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid-grant reset: got grant %b led %b busy %b want 0000 0 0",
                     grant, led, busy);
        end
        step();
        step();
        reset = 1'b0;
        ptr   = 0;
        req   = 4'b1111;
        serve(0, 0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_rate1();
        test_rates();
        test_early_release();
        test_raise0();
        test_random();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
